// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : Forwarding and hazard controller for the 5-stage 16-bit
//               pipeline. It tracks shadow destination tags for EX and MEM,
//               drives the operand-A/B forwarding mux selects, and raises
//               stall/bubble for load-use hazards. It also holds EX while the
//               multicycle multiplier runs.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int REG_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             id_is_mul,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic             ex_hold,
    output logic             mul_start,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    // The busy counter only has to hold MUL_LAT-1; keep at least one bit so
    // the design still elaborates when MUL_LAT is 1.
    localparam int c_CNT_BITS = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_CNT_BITS-1:0] c_MUL_INIT = c_CNT_BITS'(MUL_LAT - 1);
    localparam logic [c_CNT_BITS-1:0] c_CNT_ONE  = c_CNT_BITS'(1);
    localparam logic                  c_MUL_MULTI = (MUL_LAT > 1);

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_EX  = 2'b10;
    localparam logic [1:0] c_SEL_MEM = 2'b01;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_BITS-1:0] r_mul_cnt;
    logic [c_CNT_BITS-1:0] w_mul_cnt_nxt;

    // Shadow tags of the instructions currently in EX and MEM.
    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_we;
    logic             r_ex_load;
    logic             r_mem_valid;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_we;

    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic             r_mul_start;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs1_ex;
    logic w_rs2_ex;
    logic w_rs1_mem;
    logic w_rs2_mem;
    logic w_lu;
    logic w_issue;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // Source/destination tag matches; register 0 is hardwired zero and
    // therefore never forwards or causes a stall.
    always_comb begin
        w_rs1_ex  = r_ex_valid & r_ex_we & (r_ex_rd == id_rs1)
                    & (id_rs1 != '0) & id_rs1_used;
        w_rs2_ex  = r_ex_valid & r_ex_we & (r_ex_rd == id_rs2)
                    & (id_rs2 != '0) & id_rs2_used;
        w_rs1_mem = r_mem_valid & r_mem_we & (r_mem_rd == id_rs1)
                    & (id_rs1 != '0) & id_rs1_used;
        w_rs2_mem = r_mem_valid & r_mem_we & (r_mem_rd == id_rs2)
                    & (id_rs2 != '0) & id_rs2_used;
        w_lu      = id_valid & r_ex_load & (w_rs1_ex | w_rs2_ex);
    end

    // State register of the multiply sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_mul_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mul_cnt <= w_mul_cnt_nxt;
        end
    end

    // Next-state logic plus the combinational pipeline-control outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_mul_cnt_nxt = r_mul_cnt;
        stall         = 1'b0;
        bubble        = 1'b0;
        ex_hold       = 1'b0;
        w_issue       = 1'b0;
        case (r_state)
            ST_RUN: begin
                // A taken branch kills the ID instruction, so any load-use
                // hazard it carried no longer matters.
                if (flush) begin
                    bubble = 1'b1;
                end else if (w_lu) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                w_issue = id_valid & ~flush & ~w_lu;
                if (w_issue && id_is_mul && c_MUL_MULTI) begin
                    w_state_nxt   = ST_MUL_BUSY;
                    w_mul_cnt_nxt = c_MUL_INIT;
                end
            end
            ST_MUL_BUSY: begin
                // EX is occupied by the multiply and cannot resolve a
                // branch, so flush is deliberately ignored here.
                stall         = 1'b1;
                ex_hold       = 1'b1;
                w_mul_cnt_nxt = r_mul_cnt - c_CNT_ONE;
                if (r_mul_cnt == c_CNT_ONE) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt   = ST_RUN;
                w_mul_cnt_nxt = '0;
            end
        endcase
    end

    // Forwarding selects for the instruction issuing this cycle; EX wins
    // over MEM because it holds the younger result.
    always_comb begin
        w_sel_a = c_SEL_RF;
        w_sel_b = c_SEL_RF;
        if (w_issue) begin
            if (w_rs1_ex) begin
                w_sel_a = c_SEL_EX;
            end else if (w_rs1_mem) begin
                w_sel_a = c_SEL_MEM;
            end
            if (w_rs2_ex) begin
                w_sel_b = c_SEL_EX;
            end else if (w_rs2_mem) begin
                w_sel_b = c_SEL_MEM;
            end
        end
    end

    // Advance the EX/MEM tag pipeline; while the multiplier holds EX the
    // EX tag and selects freeze and MEM drains to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_we     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_we    <= 1'b0;
            r_fwd_a     <= c_SEL_RF;
            r_fwd_b     <= c_SEL_RF;
            r_mul_start <= 1'b0;
        end else if (!ex_hold) begin
            r_mem_valid <= r_ex_valid;
            r_mem_rd    <= r_ex_rd;
            r_mem_we    <= r_ex_we;
            if (w_issue) begin
                r_ex_valid <= 1'b1;
                r_ex_rd    <= id_rd;
                r_ex_we    <= id_we;
                r_ex_load  <= id_is_load;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_rd    <= '0;
                r_ex_we    <= 1'b0;
                r_ex_load  <= 1'b0;
            end
            r_fwd_a     <= w_sel_a;
            r_fwd_b     <= w_sel_b;
            r_mul_start <= w_issue & id_is_mul;
        end else begin
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mul_start <= 1'b0;
        end
    end

    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign fwd_a_sel   = r_fwd_a;
    assign fwd_b_sel   = r_fwd_b;
    assign mul_start   = r_mul_start;
    assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire
